// File: rtl/buffer_pkg.sv
// Shared types and helpers for the buffer slice.
// Used by buffer_flow_ctrl and memory_pointer.
package buffer_pkg;

  typedef enum logic {INIT, RUN} flow_state_t;

  localparam logic [31:0] POP_FIFO = "FIFO";
  localparam logic [31:0] POP_FILO = "FILO";

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/buffer_flow_ctrl.sv
// Valid/ready flow controller upstream of memory_pointer.
// Owns occupancy, flags, high-water mark and pointer reset.
module buffer_flow_ctrl
  import buffer_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] POP_ORDER = POP_FIFO,
  parameter int          AF_LEVEL  = DEPTH - 1,
  parameter int          AE_LEVEL  = 1,
  localparam int         CW        = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          push,
  output logic          pop,
  output logic          ptr_rst_n,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [CW-1:0] high_water
);

  if (POP_ORDER != POP_FIFO && POP_ORDER != POP_FILO) begin : g_bad_order
    $fatal(1, "buffer_flow_ctrl: POP_ORDER must be FIFO or FILO");
  end

  if (DEPTH < 2) begin : g_bad_depth
    $fatal(1, "buffer_flow_ctrl: DEPTH must be >= 2");
  end

  localparam bit            IS_FILO = (POP_ORDER == POP_FILO);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  flow_state_t   state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] hw_q, hw_d;
  logic          prn_q, prn_d;
  logic          run_ok;

  // A flush cycle in RUN blocks every transfer on that edge.
  always_comb begin
    run_ok       = (state_q == RUN) && !flush;
    full         = (count_q == DEPTH_C);
    empty        = (count_q == '0);
    almost_full  = (int'(count_q) >= AF_LEVEL);
    almost_empty = (int'(count_q) <= AE_LEVEL);
    out_valid    = run_ok && !empty;
    pop          = out_valid && out_ready;
    in_ready     = run_ok && !full && !(IS_FILO && pop);
    push         = in_valid && in_ready;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hw_d    = hw_q;
    if (rst) begin
      state_d = INIT;
      count_d = '0;
      hw_d    = '0;
    end else begin
      unique case (state_q)
        INIT: begin
          state_d = RUN;
        end
        RUN: begin
          if (flush) begin
            state_d = INIT;
            count_d = '0;
            hw_d    = '0;
          end else begin
            unique case ({push, pop})
              2'b10:   count_d = count_q + ONE_C;
              2'b01:   count_d = count_q - ONE_C;
              default: count_d = count_q;
            endcase
            hw_d = (count_d > hw_q) ? count_d : hw_q;
          end
        end
        default: state_d = INIT;
      endcase
    end
    prn_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    count_q <= count_d;
    hw_q    <= hw_d;
    prn_q   <= prn_d;
  end

  assign ptr_rst_n  = prn_q;
  assign count      = count_q;
  assign high_water = hw_q;

endmodule
